// File: rtl/upsample_pkg.sv
// Shared definitions for the 2x upsampler sequencer and its sibling downsampler controller.
// Contents:
//   state_e    - sequencer states (idle, two live-pixel phases, line-buffer replay, done)
//   *_DEF      - default image geometry and pixel width
//   OUT_*_DEF  - output geometry derived from the defaults
//   out_dim()  - output dimension for a given input dimension
package upsample_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEmitA,
        StEmitB,
        StReplay,
        StDone
    } state_e;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IN_W_DEF   = 800;
    localparam int unsigned IN_H_DEF   = 600;

    localparam int unsigned OUT_W_DEF  = 2 * IN_W_DEF;
    localparam int unsigned OUT_H_DEF  = 2 * IN_H_DEF;

    function automatic int unsigned out_dim(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/upsample_pos_cnt.sv
// Output position tracker: column/row counter pair.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   clr              - clear both counters to zero
//   inc              - advance the column by one
//   wrap             - return the column to zero (takes priority over inc)
//   row_inc          - advance the row by one
//   col, row         - current position
//   last_col         - column is at LAST_COL
//   last_row         - row is at LAST_ROW
module upsample_pos_cnt #(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned LAST_COL = 1599,
    parameter int unsigned LAST_ROW = 1199
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             wrap,
    input  logic             row_inc,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last_col,
    output logic             last_row
);

    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            if (wrap) begin
                col_q <= '0;
            end else if (inc) begin
                col_q <= col_q + CNT_W'(1);
            end
            if (row_inc) begin
                row_q <= row_q + CNT_W'(1);
            end
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign last_col = (col_q == CNT_W'(LAST_COL));
    assign last_row = (row_q == CNT_W'(LAST_ROW));

endmodule

// File: rtl/upsample_sched.sv
// Sequencer feeding a 2x image upsampler from an FWFT pixel FIFO.
// Each popped pixel is sent twice (horizontal duplicate); every live row is followed by a row of
// replay strobes during which the upsampler's line buffer supplies the vertical duplicate.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - one-cycle pulse, starts a frame when idle
//   busy, frame_done         - frame in progress / one-cycle completion pulse
//   fifo_empty, fifo_dout    - FWFT FIFO status and head pixel
//   fifo_rd_en               - pop the FIFO head
//   out_ready                - downstream accepts a pixel this cycle
//   us_valid, us_din         - pixel strobe and data to the upsampler
//   us_replay                - strobe is served from the line buffer
//   row, col                 - current output position
//   stall_cycles             - stall cycle count, present only with UPSAMPLE_SCHED_STALL_CNT_EN
module upsample_sched
    import upsample_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned IN_H   = IN_H_DEF,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    input  logic              out_ready,
    output logic              us_valid,
    output logic [DATA_W-1:0] us_din,
    output logic              us_replay,
    output logic [CNT_W-1:0]  row,
    output logic [CNT_W-1:0]  col
`ifdef UPSAMPLE_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    state_e            state_q;
    logic [DATA_W-1:0] pix_q;
    logic              xfer;
    logic              last_col;
    logic              last_row;
    logic              row_inc;

    // Strobes are decoded straight from state so a pixel moves in the cycle it is offered.
    always_comb begin
        us_valid   = 1'b0;
        fifo_rd_en = 1'b0;
        us_replay  = 1'b0;
        us_din     = '0;
        unique case (state_q)
            StEmitA: begin
                us_valid   = !fifo_empty && out_ready;
                us_din     = fifo_dout;
                fifo_rd_en = !fifo_empty && out_ready;
            end
            StEmitB: begin
                us_valid = out_ready;
                us_din   = pix_q;
            end
            StReplay: begin
                us_valid  = out_ready;
                us_replay = 1'b1;
            end
            default: ;
        endcase
        // Nothing may leave or be popped while reset is held.
        if (rst) begin
            us_valid   = 1'b0;
            fifo_rd_en = 1'b0;
            us_replay  = 1'b0;
        end
    end

    assign xfer = us_valid && out_ready;

    // The last replay strobe of the last row leaves row alone; DONE clears both counters.
    assign row_inc = xfer && last_col && !((state_q == StReplay) && last_row);

    upsample_pos_cnt #(
        .CNT_W    (CNT_W),
        .LAST_COL (out_dim(IN_W) - 1),
        .LAST_ROW (out_dim(IN_H) - 1)
    ) u_pos_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == StDone),
        .inc      (xfer),
        .wrap     (xfer && last_col),
        .row_inc  (row_inc),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pix_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_q <= StEmitA;
                end
                StEmitA: begin
                    if (xfer) begin
                        pix_q   <= fifo_dout;
                        state_q <= StEmitB;
                    end
                end
                StEmitB: begin
                    if (xfer) state_q <= last_col ? StReplay : StEmitA;
                end
                StReplay: begin
                    if (xfer && last_col) state_q <= last_row ? StDone : StEmitA;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

`ifdef UPSAMPLE_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_hit;

    // Starved and back-pressured in the same cycle still counts as one stall cycle.
    assign stall_hit = ((state_q == StEmitA) && fifo_empty) ||
                       ((state_q inside {StEmitA, StEmitB, StReplay}) && !out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            stall_q <= '0;
        end else if (stall_hit && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_upsample_sched.sv
// Self-checking bench for upsample_sched with a small image (4x2 in, 8x4 out).
module tb_upsample_sched;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IN_W   = 4;
    localparam int unsigned IN_H   = 2;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OUT_W  = 2 * IN_W;
    localparam int unsigned PIXELS = IN_W * IN_H;
    localparam int unsigned XFERS  = 4 * IN_W * IN_H;

    typedef struct packed {
        logic [DATA_W-1:0] din;
        logic              replay;
        logic [CNT_W-1:0]  row;
        logic [CNT_W-1:0]  col;
    } xfer_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              frame_done;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_dout = '0;
    logic              fifo_rd_en;
    logic              out_ready = 1'b0;
    logic              us_valid;
    logic [DATA_W-1:0] us_din;
    logic              us_replay;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
`ifdef UPSAMPLE_SCHED_STALL_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    upsample_sched #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .out_ready    (out_ready),
        .us_valid     (us_valid),
        .us_din       (us_din),
        .us_replay    (us_replay),
        .row          (row),
        .col          (col)
`ifdef UPSAMPLE_SCHED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial forever #5 clk = ~clk;

    // Bench state
    logic [DATA_W-1:0] fifo_q[$];
    xfer_t             exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                xfer_cnt = 0;
    int                pop_cnt = 0;
    int                done_cnt = 0;
    int                ready_low_cnt = 0;
    bit                in_frame = 1'b0;
    bit                pop_pending = 1'b0;
    bit                rand_ready = 1'b0;
    bit                ready_cmd = 1'b1;
    bit                force_empty = 1'b0;
    logic [DATA_W-1:0] first_pix = '0;
    xfer_t             mon_act;
    xfer_t             mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is IN_H pairs of (live row, replay row); a live row shows each
    // input pixel twice in order, a replay row carries OUT_W line-buffer strobes with din 0.
    task automatic load_frame(input bit seq);
        logic [DATA_W-1:0] pix [PIXELS];
        xfer_t e;
        for (int i = 0; i < int'(PIXELS); i++) begin
            pix[i] = seq ? DATA_W'(i + 1) : DATA_W'($urandom);
            fifo_q.push_back(pix[i]);
        end
        first_pix = pix[0];
        for (int r = 0; r < int'(IN_H); r++) begin
            for (int k = 0; k < int'(OUT_W); k++) begin
                e.din    = pix[r * int'(IN_W) + k / 2];
                e.replay = 1'b0;
                e.row    = CNT_W'(2 * r);
                e.col    = CNT_W'(k);
                exp_q.push_back(e);
            end
            for (int k = 0; k < int'(OUT_W); k++) begin
                e.din    = '0;
                e.replay = 1'b1;
                e.row    = CNT_W'(2 * r + 1);
                e.col    = CNT_W'(k);
                exp_q.push_back(e);
            end
        end
    endtask

    // FIFO model and input driver: act after the edge, clear of DUT sampling.
    initial forever begin
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        #1;
        out_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (in_frame && !out_ready) ready_low_cnt++;
        if (fifo_rd_en) begin
            pop_cnt++;
            pop_pending = 1'b1;
            check("pop_nonempty", 64'(fifo_empty), 64'(0));
        end
        if (frame_done) done_cnt++;
        if (us_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_xfer: got din %0h row %0d col %0d expected none (t=%0t)",
                         us_din, row, col, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act.din    = us_din;
                mon_act.replay = us_replay;
                mon_act.row    = row;
                mon_act.col    = col;
                check("xfer{din,replay,row,col}", 64'(mon_act), 64'(mon_exp));
                if (exp_q.size() == 0) in_frame = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_frame = 1'b1;
    endtask

    task automatic wait_pos(input int r, input int c, input bit need_xfer, input string tag);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 4000) begin
            tick();
            n++;
            hit = (row == CNT_W'(r)) && (col == CNT_W'(c)) && (!need_xfer || (us_valid && out_ready));
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, row %0d col %0d expected row %0d col %0d", tag, row, col, r, c);
        end
    endtask

    task automatic wait_done(input int base_done);
        int n = 0;
        while (done_cnt == base_done && n < 4000) begin
            tick();
            n++;
        end
        if (done_cnt == base_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got no frame_done expected one");
        end
    endtask

    task automatic end_checks(input string tag, input int bx, input int bp, input int bd,
                              input int exp_stall);
        tick();
        check({tag, "_xfers"}, 64'(xfer_cnt - bx), 64'(XFERS));
        check({tag, "_pops"}, 64'(pop_cnt - bp), 64'(PIXELS));
        check({tag, "_done_once"}, 64'(done_cnt - bd), 64'(1));
        check({tag, "_busy_low"}, 64'(busy), 64'(0));
        check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'(0));
`ifdef UPSAMPLE_SCHED_STALL_CNT_EN
        check({tag, "_stall"}, 64'(stall_cycles), 64'(exp_stall));
`else
        if (exp_stall < 0) $display("negative stall expectation in %s", tag);
`endif
    endtask

    task automatic run_plain_frame(input string tag);
        int bx, bp, bd;
        bx = xfer_cnt; bp = pop_cnt; bd = done_cnt;
        load_frame(1'b1);
        do_start();
        wait_done(bd);
        end_checks(tag, bx, bp, bd, 0);
    endtask

    initial begin
        int bx, bp, bd;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_us_valid", 64'(us_valid), 64'(0));
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_replay", 64'(us_replay), 64'(0));
        check("rst_row", 64'(row), 64'(0));
        check("rst_col", 64'(col), 64'(0));

        // Basic frame, pixels 1..8
        run_plain_frame("basic");

        // FIFO starved for 5 cycles in EMIT_A at col 2
        bx = xfer_cnt; bp = pop_cnt; bd = done_cnt;
        load_frame(1'b0);
        do_start();
        wait_pos(0, 1, 1'b0, "empty_wait");
        @(posedge clk);
        #1 force_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_us_valid", 64'(us_valid), 64'(0));
            check("empty_rd_en", 64'(fifo_rd_en), 64'(0));
            check("empty_col", 64'(col), 64'(2));
        end
        @(posedge clk);
        #1 force_empty = 1'b0;
        wait_done(bd);
        end_checks("empty", bx, bp, bd, 5);

        // Backpressure: 3 cycles in EMIT_B, then 3 cycles in REPLAY
        bx = xfer_cnt; bp = pop_cnt; bd = done_cnt;
        load_frame(1'b0);
        do_start();
        wait_pos(0, 0, 1'b1, "bp_b_wait");
        @(posedge clk);
        #1 ready_cmd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_b_us_valid", 64'(us_valid), 64'(0));
            check("bp_b_rd_en", 64'(fifo_rd_en), 64'(0));
            check("bp_b_col", 64'(col), 64'(1));
            check("bp_b_din_held", 64'(us_din), 64'(first_pix));
        end
        @(posedge clk);
        #1 ready_cmd = 1'b1;
        wait_pos(1, 0, 1'b1, "bp_r_wait");
        @(posedge clk);
        #1 ready_cmd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_r_us_valid", 64'(us_valid), 64'(0));
            check("bp_r_replay", 64'(us_replay), 64'(1));
            check("bp_r_col", 64'(col), 64'(1));
        end
        @(posedge clk);
        #1 ready_cmd = 1'b1;
        wait_done(bd);
        end_checks("bp", bx, bp, bd, 6);

        // Random backpressure plus a start pulse while busy at row 1, col 3
        bx = xfer_cnt; bp = pop_cnt; bd = done_cnt;
        ready_low_cnt = 0;
        rand_ready = 1'b1;
        load_frame(1'b0);
        do_start();
        wait_pos(1, 3, 1'b0, "restart_wait");
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tick();
        check("restart_busy", 64'(busy), 64'(1));
        wait_done(bd);
        end_checks("restart", bx, bp, bd, ready_low_cnt);
        rand_ready = 1'b0;

        // Reset in EMIT_B at row 2, col 1
        bd = done_cnt;
        load_frame(1'b1);
        do_start();
        wait_pos(2, 0, 1'b1, "rst_mid_wait");
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("rstmid_col_b", 64'(col), 64'(1));
        check("rstmid_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rstmid_us_valid", 64'(us_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_row", 64'(row), 64'(0));
        check("rstmid_col", 64'(col), 64'(0));
        check("rstmid_no_pop", 64'(fifo_rd_en), 64'(0));
        check("rstmid_no_done", 64'(done_cnt - bd), 64'(0));
        exp_q.delete();
        fifo_q.delete();
        in_frame = 1'b0;
        run_plain_frame("after_rst");

        // FIFO empty for the whole frame
        do_start();
        in_frame = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("starve_busy", 64'(busy), 64'(1));
            check("starve_us_valid", 64'(us_valid), 64'(0));
            check("starve_rd_en", 64'(fifo_rd_en), 64'(0));
            check("starve_col", 64'(col), 64'(0));
`ifdef UPSAMPLE_SCHED_STALL_CNT_EN
            check("starve_stall", 64'(stall_cycles), 64'(i));
`endif
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("final_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/upsample_sched.md
Name: upsample_sched

Overview:
- Sequencer that feeds the 2x image upsampler from a first-word-fall-through (FWFT) pixel FIFO.
- Pops one input pixel and drives it into the upsampler twice (horizontal duplicate), giving 2*IN_W live output pixels per row.
- After each live row, drives 2*IN_W replay strobes with no FIFO reads, during which the upsampler's line buffer supplies the duplicate row.
- Tracks output row/column, honours downstream backpressure and reports frame completion.

Parameters:
- DATA_W, 8, pixel width.
- IN_W, 800, input image width in pixels.
- IN_H, 600, input image height in rows.
- CNT_W, 11, width of the output row/col counters; must satisfy 2^CNT_W > 2*max(IN_W, IN_H).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last output pixel.
- fifo_empty  in  1  input FIFO empty; fifo_dout is valid when low.
- fifo_dout  in  DATA_W  FWFT head pixel.
- fifo_rd_en  out  1  pops the FIFO head.
- out_ready  in  1  upsampler/downstream accepts a pixel this cycle.
- us_valid  out  1  pixel strobe to the upsampler.
- us_din  out  DATA_W  pixel to the upsampler.
- us_replay  out  1  high on strobes whose output comes from the line buffer.
- row  out  CNT_W  current output row, 0..2*IN_H-1.
- col  out  CNT_W  current output column, 0..2*IN_W-1.

Behaviour:
- Reset: state IDLE; row=0, col=0; pix_q=0; busy=0, frame_done=0. All strobes (us_valid, fifo_rd_en, us_replay) are low.
- rst mid-frame: next cycle is IDLE with counters at 0. No pop occurs in the rst cycle. The FIFO is not flushed.
- States: IDLE, EMIT_A, EMIT_B, REPLAY, DONE. Strobe outputs are combinational from state and inputs, so output latency is zero cycles.
- A transfer occurs when us_valid=1 and out_ready=1. col increments only on a transfer.

State transitions:
- IDLE: on start, go to EMIT_A; row and col are already 0. Otherwise stay.
- EMIT_A: us_valid = !fifo_empty && out_ready; us_din = fifo_dout; fifo_rd_en = us_valid.
  - On a transfer: pix_q <= fifo_dout, col++, go to EMIT_B.
  - If fifo_empty or !out_ready: stay, no pop.
- EMIT_B: us_valid = out_ready; us_din = pix_q; no pop.
  - On a transfer at col=2*IN_W-1: col <= 0, row++, go to REPLAY.
  - On any other transfer: col++, go to EMIT_A.
- REPLAY: us_valid = out_ready; us_replay = 1; us_din = 0; no pop.
  - On a transfer at col=2*IN_W-1: col <= 0.
    - If row=2*IN_H-1, go to DONE.
    - Otherwise row++ and go to EMIT_A.
  - On any other transfer: col++.
- DONE: frame_done=1 for one cycle; row <= 0, col <= 0; go to IDLE.

Boundary and corner rules:
- busy = (state != IDLE).
- start while busy is ignored, with no restart and no counter effect.
- fifo_empty never stalls EMIT_B or REPLAY.
- Counters wrap only through the explicit rules above; arithmetic is unsigned CNT_W.
- Exactly IN_W*IN_H pops per frame.
- Exactly 4*IN_W*IN_H transfers per frame; half of them have us_replay=1.

Optional Feature:
- Macro UPSAMPLE_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Counts cycles in EMIT_A with fifo_empty=1, plus cycles in EMIT_A/EMIT_B/REPLAY with out_ready=0. A cycle meeting both conditions counts once.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst and by an accepted start; holds its value after frame_done.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package upsample_pkg holds:
  - the state enum (IDLE, EMIT_A, EMIT_B, REPLAY, DONE);
  - default IN_W/IN_H/DATA_W constants;
  - derived OUT_W=2*IN_W and OUT_H=2*IN_H.
- One sub-module, upsample_pos_cnt: the col/row counter pair with inc, wrap and clear inputs and last_col/last_row flags. It is reused by the downsampler controller.

Test Plan:
- IN_W=4, IN_H=2, FIFO preloaded 1..8, out_ready=1, start pulse.
  - Row 0 transfers: 1,1,2,2,3,3,4,4. Row 1: 8 replay strobes. Rows 2–3 repeat this with pixels 5..8.
  - Expect 32 transfers, 8 pops, frame_done pulsed once, busy low afterwards.
- FIFO empty for 5 cycles in EMIT_A at col=2.
  - us_valid and fifo_rd_en are low for those 5 cycles; col holds at 2.
  - When the FIFO refills: no duplicated or lost pixel, and the stall counter (if enabled) reads 5.
- out_ready low for 3 cycles in EMIT_B, then 3 cycles in REPLAY.
  - us_din is held at pix_q; no pop and no col change during the stall.
  - Frame still completes with exactly 32 transfers.
- start pulsed again at row=1, col=3.
  - Ignored: the frame finishes normally and frame_done pulses exactly once.
- rst asserted at row=2, col=1 in EMIT_B.
  - Next cycle: IDLE, row=0, col=0, busy=0, no pop.
  - A fresh start with a refilled FIFO reproduces scenario 1.
- Upstream FIFO empty for the whole frame with out_ready=1 (DUT sits in EMIT_A at row 0, col 0).
  - Stall counter increments every cycle; busy stays high; no strobes.
